// File: rtl/ssp_clk_sched.sv
// ---------------------------------------------------------------------------
// ssp_clk_sched
//   Two-requester round-robin scheduler for a serial (SSP) clock generator.
//   A granted requester owns the serial clock for one frame: a SETUP phase,
//   LEN+1 high phases of SSPCLK separated by low phases, and a trailing HOLD
//   phase that doubles as the final low phase. Every phase is DIV+1 PCLK
//   cycles long. DIV and the granted LEN are captured at grant time.
//
// Ports
//   i_pclk        : sole clock, rising edge
//   i_clear       : asynchronous active-high reset
//   i_req[1:0]    : per-requester frame request, held until that frame's DONE
//   i_len0/i_len1 : frame length minus one for requester 0 / 1
//   i_div         : SSPCLK half-period in PCLK cycles, minus one
//   o_gnt[1:0]    : one-hot grant, held for the whole frame
//   o_busy        : high whenever the scheduler is not idle
//   o_sspclk_out  : registered serial clock, idle low
//   o_bit_stb     : one-cycle pulse in the first cycle of each SSPCLK high phase
//   o_done        : one-cycle pulse in the last cycle of the frame
// ---------------------------------------------------------------------------
module ssp_clk_sched #(
  parameter int DIV_W = 8,
  parameter int LEN_W = 5
) (
  input  logic             i_pclk,
  input  logic             i_clear,
  input  logic [1:0]       i_req,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  input  logic [DIV_W-1:0] i_div,
  output logic [1:0]       o_gnt,
  output logic             o_busy,
  output logic             o_sspclk_out,
  output logic             o_bit_stb,
  output logic             o_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACTIVE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [DIV_W-1:0] r_div;      // divisor captured at grant
  logic [LEN_W-1:0] r_len;      // granted requester's length captured at grant
  logic [DIV_W-1:0] r_cnt;      // half-period down-counter
  logic [LEN_W:0]   r_bits;     // SSPCLK rises issued so far in this frame
  logic [1:0]       r_gnt;
  logic             r_last;     // 1 when requester 1 was granted last
  logic             r_sspclk;
  logic             r_bit_stb;

  logic             w_phase_end;
  logic             w_last_bit;
  logic             w_pick1;
  logic [LEN_W:0]   w_len_p1;

  assign w_phase_end = (r_cnt == '0);
  assign w_len_p1    = {1'b0, r_len} + (LEN_W+1)'(1);
  // All LEN+1 high phases have been issued; the next fall ends ACTIVE.
  assign w_last_bit  = (r_bits == w_len_p1);
  // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
  assign w_pick1     = i_req[1] & (~i_req[0] | ~r_last);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge i_pclk or posedge i_clear) begin
    if (i_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (|i_req)      w_state_next = S_SETUP;
      S_SETUP:  if (w_phase_end) w_state_next = S_ACTIVE;
      // The fall after the last high phase goes straight into HOLD, which
      // then serves as the frame's final low phase.
      S_ACTIVE: if (w_phase_end && r_sspclk && w_last_bit) w_state_next = S_HOLD;
      S_HOLD:   if (w_phase_end) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    o_busy       = (r_state != S_IDLE);
    o_done       = (r_state == S_HOLD) && w_phase_end;
    o_gnt        = r_gnt;
    o_sspclk_out = r_sspclk;
    o_bit_stb    = r_bit_stb;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge i_pclk or posedge i_clear) begin
    if (i_clear) begin
      r_div     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_bits    <= '0;
      r_gnt     <= 2'b00;
      r_last    <= 1'b1;
      r_sspclk  <= 1'b0;
      r_bit_stb <= 1'b0;
    end else begin
      r_bit_stb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_gnt  <= w_pick1 ? 2'b10 : 2'b01;
            r_last <= w_pick1;
            r_div  <= i_div;
            r_len  <= w_pick1 ? i_len1 : i_len0;
            r_cnt  <= i_div;
            r_bits <= '0;
          end
        end
        S_SETUP: begin
          if (w_phase_end) begin
            r_cnt     <= r_div;
            r_sspclk  <= 1'b1;
            r_bit_stb <= 1'b1;
            r_bits    <= r_bits + (LEN_W+1)'(1);
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        S_ACTIVE: begin
          if (w_phase_end) begin
            r_cnt <= r_div;
            if (r_sspclk) begin
              // Falls are identical whether or not this is the last bit.
              r_sspclk <= 1'b0;
            end else begin
              r_sspclk  <= 1'b1;
              r_bit_stb <= 1'b1;
              r_bits    <= r_bits + (LEN_W+1)'(1);
            end
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (w_phase_end) begin
            r_gnt <= 2'b00;
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        default: begin
          r_gnt    <= 2'b00;
          r_sspclk <= 1'b0;
        end
      endcase
    end
  end

endmodule
